// File: rtl/fx_pkg.sv
// Shared types and format helpers for the fixed-point requantiser.
package fx_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'd0,
        RND_HALF_UP   = 2'd1,
        RND_HALF_EVEN = 2'd2,
        RND_RSVD      = 2'd3
    } rnd_mode_e;

    function automatic int fx_frac(input int w, input int s, input int i);
        return w - s - i;
    endfunction

    function automatic longint fx_max(input int w, input int s, input int i);
        return (longint'(1) <<< (i + fx_frac(w, s, i))) - 1;
    endfunction

    function automatic longint fx_min(input int w, input int s, input int i);
        return -(longint'(1) <<< (i + fx_frac(w, s, i)));
    endfunction

    // Interpreted input bits, one guard bit, plus any exact left shift.
    function automatic int fx_mid_width(
        input int fw, input int fs, input int fi,
        input int w, input int s, input int i
    );
        int fin;
        int fout;
        fin  = fx_frac(fw, fs, fi);
        fout = fx_frac(w, s, i);
        return fi + 2 + fin + ((fout > fin) ? fout - fin : 0);
    endfunction

endpackage

// File: rtl/fx_lane_conv.sv
// One lane of the requantiser; stage 0 rounds, stage 1 saturates.
module fx_lane_conv
    import fx_pkg::*;
#(
    parameter int stage          = 0,
    parameter int from_width     = 12,
    parameter int from_sign_bits = 1,
    parameter int from_int_bits  = 3,
    parameter int width          = 6,
    parameter int sign_bits      = 1,
    parameter int int_bits       = 2,
    localparam int mid_width = fx_mid_width(from_width, from_sign_bits,
        from_int_bits, width, sign_bits, int_bits)
) (
    input  logic [from_width-1:0] word,
    input  rnd_mode_e             mode,
    input  logic [mid_width-1:0]  mid_in,
    output logic [mid_width-1:0]  mid_out,
    output logic [width-1:0]      result,
    output logic                  ovf
);

    localparam int frac_in  = fx_frac(from_width, from_sign_bits, from_int_bits);
    localparam int frac_out = fx_frac(width, sign_bits, int_bits);
    localparam int in_bits  = from_int_bits + 1 + frac_in;

    if (stage == 0) begin : g_round
        logic [in_bits-1:0] x;
        logic               unused_in;

        assign x         = word[in_bits-1:0];
        assign unused_in = ^{mid_in, word};
        assign result    = '0;
        assign ovf       = 1'b0;

        if (frac_out >= frac_in) begin : g_left
            localparam int sh = frac_out - frac_in;
            assign mid_out = {{(mid_width-in_bits){x[in_bits-1]}}, x} << sh;
        end else begin : g_right
            localparam int d = frac_in - frac_out;
            localparam logic [in_bits:0] half = {{in_bits{1'b0}}, 1'b1} << (d - 1);
            logic        [in_bits:0] ext;
            logic        [in_bits:0] inc;
            logic signed [in_bits:0] sum;

            assign ext = {x[in_bits-1], x};

            always_comb begin
                inc = half;
                unique case (1'b1)
                    mode == RND_TRUNC: inc = '0;
                    // Exact tie onto an even kept value stays put.
                    mode == RND_HALF_EVEN && x[d-1:0] == half[d-1:0] && !x[d]:
                        inc = '0;
                    default: inc = half;
                endcase
            end

            assign sum     = ext + inc;
            assign mid_out = sum >>> d;
        end
    end else begin : g_sat
        localparam int cmp_width = mid_width + width + 1;
        localparam logic signed [cmp_width-1:0] max_v =
            cmp_width'(fx_max(width, sign_bits, int_bits));
        localparam logic signed [cmp_width-1:0] min_v =
            cmp_width'(fx_min(width, sign_bits, int_bits));
        logic signed [cmp_width-1:0] v;
        logic                        unused_in;

        assign v         = {{(width+1){mid_in[mid_width-1]}}, mid_in};
        assign unused_in = ^{word, mode};
        assign mid_out   = '0;

        always_comb begin
            result = v[width-1:0];
            ovf    = 1'b0;
            unique case (1'b1)
                v > max_v: begin
                    result = max_v[width-1:0];
                    ovf    = 1'b1;
                end
                v < min_v: begin
                    result = min_v[width-1:0];
                    ovf    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fx_requant_pipe.sv
// Multi-lane fixed-point format converter: 2-stage valid/ready pipe
// with per-beat saturation flags and a saturating overflow counter.
module fx_requant_pipe
    import fx_pkg::*;
#(
    parameter int lanes          = 4,
    parameter int from_width     = 12,
    parameter int from_sign_bits = 1,
    parameter int from_int_bits  = 3,
    parameter int width          = 6,
    parameter int sign_bits      = 1,
    parameter int int_bits       = 2,
    parameter int cnt_width      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [lanes*from_width-1:0] in_data,
    input  logic [1:0]                  rnd_mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [lanes*width-1:0]      out_data,
    output logic [lanes-1:0]            out_ovf,
    output logic [cnt_width-1:0]        ovf_count,
    input  logic                        ovf_clear
);

    localparam int mid_width = fx_mid_width(from_width, from_sign_bits,
        from_int_bits, width, sign_bits, int_bits);

    if (fx_frac(from_width, from_sign_bits, from_int_bits) < 0 ||
        from_sign_bits < 1) begin : g_bad_from
        $fatal(1, "fx_requant_pipe: illegal input format");
    end
    if (fx_frac(width, sign_bits, int_bits) < 0 || sign_bits < 1) begin : g_bad_to
        $fatal(1, "fx_requant_pipe: illegal output format");
    end

    logic                         s1_valid;
    logic                         s2_valid;
    logic [lanes*mid_width-1:0]   s1_mid;
    rnd_mode_e                    s1_mode;
    logic [lanes*width-1:0]       s2_data;
    logic [lanes-1:0]             s2_ovf;
    logic [lanes*mid_width-1:0]   mid_c;
    logic [lanes*width-1:0]       data_c;
    logic [lanes-1:0]             ovf_c;
    logic                         s1_adv;
    logic                         s2_adv;
    logic                         take;
    logic [cnt_width-1:0]         count;
    logic [cnt_width:0]           pop;
    logic [cnt_width:0]           sum_c;
    logic                         unused_mode;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = !reset && s1_adv;
    assign take     = in_valid && in_ready;

    for (genvar i = 0; i < lanes; i++) begin : g_lane
        logic [mid_width-1:0] unused_mid;
        logic [width-1:0]     unused_res;
        logic                 unused_ovf;

        fx_lane_conv #(
            .stage(0),
            .from_width(from_width),
            .from_sign_bits(from_sign_bits),
            .from_int_bits(from_int_bits),
            .width(width),
            .sign_bits(sign_bits),
            .int_bits(int_bits)
        ) u_rnd (
            .word(in_data[i*from_width +: from_width]),
            .mode(rnd_mode_e'(rnd_mode)),
            .mid_in('0),
            .mid_out(mid_c[i*mid_width +: mid_width]),
            .result(unused_res),
            .ovf(unused_ovf)
        );

        fx_lane_conv #(
            .stage(1),
            .from_width(from_width),
            .from_sign_bits(from_sign_bits),
            .from_int_bits(from_int_bits),
            .width(width),
            .sign_bits(sign_bits),
            .int_bits(int_bits)
        ) u_sat (
            .word('0),
            .mode(RND_TRUNC),
            .mid_in(s1_mid[i*mid_width +: mid_width]),
            .mid_out(unused_mid),
            .result(data_c[i*width +: width]),
            .ovf(ovf_c[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_mid   <= '0;
            s1_mode  <= RND_TRUNC;
            s2_data  <= '0;
            s2_ovf   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= take;
                if (take) begin
                    s1_mid  <= mid_c;
                    s1_mode <= rnd_mode_e'(rnd_mode);
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= data_c;
                    s2_ovf  <= ovf_c;
                end
            end
        end
    end

    assign unused_mode = ^s1_mode;

    always_comb begin
        pop = '0;
        for (int i = 0; i < lanes; i++) begin
            pop = pop + {{cnt_width{1'b0}}, s2_ovf[i]};
        end
        sum_c = {1'b0, count} + pop;
    end

    // Clear wins over a coinciding transfer.
    always_ff @(posedge clk) begin
        if (reset || ovf_clear) begin
            count <= '0;
        end else if (s2_valid && out_ready) begin
            count <= sum_c[cnt_width] ? '1 : sum_c[cnt_width-1:0];
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_ovf   = s2_ovf;
    assign ovf_count = count;

endmodule

// File: tb/tb_fx_requant_pipe.sv
// Directed self-checking bench for fx_requant_pipe.
module tb_fx_requant_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic [1:0]  rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [3:0]  out_ovf;
    logic [15:0] ovf_count;
    logic        ovf_clear;

    logic        c_in_ready;
    logic        c_out_valid;
    logic [23:0] c_out_data;
    logic [3:0]  c_out_ovf;
    logic [3:0]  c_count;

    logic        x_valid;
    logic        x_ready;
    logic [1:0]  x_mode;
    logic        x_clear;
    logic        a_in_ready;
    logic [25:0] a_in;
    logic        a_out_valid;
    logic [11:0] a_out;
    logic [0:0]  a_ovf;
    logic [15:0] a_count;
    logic        b_in_ready;
    logic [11:0] b_in;
    logic        b_out_valid;
    logic [23:0] b_out;
    logic [0:0]  b_ovf;
    logic [15:0] b_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fx_requant_pipe u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rnd_mode(rnd_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf),
        .ovf_count(ovf_count), .ovf_clear(ovf_clear)
    );

    fx_requant_pipe #(.cnt_width(4)) u_cnt4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
        .rnd_mode(rnd_mode),
        .out_valid(c_out_valid), .out_ready(out_ready),
        .out_data(c_out_data), .out_ovf(c_out_ovf),
        .ovf_count(c_count), .ovf_clear(ovf_clear)
    );

    fx_requant_pipe #(
        .lanes(1), .from_width(26), .from_sign_bits(2), .from_int_bits(24),
        .width(12), .sign_bits(1), .int_bits(3)
    ) u_fmt_a (
        .clk(clk), .reset(reset),
        .in_valid(x_valid), .in_ready(a_in_ready), .in_data(a_in),
        .rnd_mode(x_mode),
        .out_valid(a_out_valid), .out_ready(x_ready),
        .out_data(a_out), .out_ovf(a_ovf),
        .ovf_count(a_count), .ovf_clear(x_clear)
    );

    fx_requant_pipe #(
        .lanes(1), .from_width(12), .from_sign_bits(1), .from_int_bits(3),
        .width(24), .sign_bits(2), .int_bits(6)
    ) u_fmt_b (
        .clk(clk), .reset(reset),
        .in_valid(x_valid), .in_ready(b_in_ready), .in_data(b_in),
        .rnd_mode(x_mode),
        .out_valid(b_out_valid), .out_ready(x_ready),
        .out_data(b_out), .out_ovf(b_ovf),
        .ovf_count(b_count), .ovf_clear(x_clear)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [47:0] d, input logic [1:0] m);
        in_valid = 1'b1;
        in_data  = d;
        rnd_mode = m;
        tick();
        in_valid = 1'b0;
    endtask

    // Beat k: lane i holds exactly (k+i) output LSBs, so any mode is exact.
    function automatic logic [47:0] beat_in(input int k);
        logic [47:0] r;
        for (int i = 0; i < 4; i++) r[i*12 +: 12] = 12'((k + i) * 32);
        return r;
    endfunction

    function automatic logic [23:0] beat_out(input int k);
        logic [23:0] r;
        for (int i = 0; i < 4; i++) r[i*6 +: 6] = 6'(k + i);
        return r;
    endfunction

    initial begin
        logic [47:0] sat_beat;
        logic [31:0] pat;
        logic [23:0] held_d;
        logic        held_v;
        logic        acc;
        int          next;
        int          got;
        int          n;
        int          first_acc;
        int          first_val;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        rnd_mode  = 2'd0;
        out_ready = 1'b1;
        ovf_clear = 1'b0;
        x_valid   = 1'b0;
        x_ready   = 1'b1;
        x_mode    = 2'd0;
        x_clear   = 1'b0;
        a_in      = '0;
        b_in      = '0;
        sat_beat  = {12'h7ff, 12'h800, 12'h000, 12'h000};

        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_count", ovf_count, 0);
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // Rounding of 3 - 2^-8
        send({36'h0, 12'h2ff}, 2'd1);
        check("t1_early_valid", out_valid, 0);
        tick();
        check("t1_half_up_valid", out_valid, 1);
        check("t1_half_up", out_data, {18'h0, 6'h18});
        check("t1_half_up_ovf", out_ovf, 0);
        send({36'h0, 12'h2ff}, 2'd0);
        tick();
        check("t1_trunc", out_data, {18'h0, 6'h17});

        // Ties and positive saturation
        send({12'h7ff, 12'hff0, 12'h030, 12'h010}, 2'd2);
        tick();
        check("t2_half_even", out_data, {6'h1f, 6'h00, 6'h02, 6'h00});
        check("t2_half_even_ovf", out_ovf, 4'b1000);
        send({12'h7ff, 12'hff0, 12'h030, 12'h010}, 2'd1);
        tick();
        check("t2_half_up", out_data, {6'h1f, 6'h00, 6'h02, 6'h01});
        check("t2_half_up_ovf", out_ovf, 4'b1000);
        tick();
        check("t2_count", ovf_count, 2);

        // Other formats
        x_valid = 1'b1;
        a_in    = 26'h3fffff2;
        b_in    = 12'h7ff;
        tick();
        x_valid = 1'b0;
        tick();
        check("t3a_valid", a_out_valid, 1);
        check("t3a_data", a_out, 12'h800);
        check("t3a_ovf", a_ovf, 1);
        check("t3b_valid", b_out_valid, 1);
        check("t3b_data", b_out, 24'h07ff00);
        check("t3b_ovf", b_ovf, 0);
        tick();
        check("t3a_count", a_count, 1);
        check("t3b_count", b_count, 0);

        // Stream with stalls
        pat       = 32'b1011_0010_1110_0111_0101_1001_1100_1101;
        next      = 1;
        got       = 0;
        n         = 0;
        held_v    = 1'b0;
        held_d    = '0;
        first_acc = -1;
        first_val = -1;
        rnd_mode  = 2'd0;
        while (got < 20 && n < 300) begin
            if (held_v) begin
                check("t4_hold_valid", out_valid, 1);
                check("t4_hold_data", out_data, held_d);
            end
            if (out_valid && first_val < 0) first_val = n;
            in_valid  = (next <= 20);
            in_data   = beat_in(next);
            out_ready = pat[n % 32];
            #1;
            acc = in_valid && in_ready;
            if (acc && first_acc < 0) first_acc = n;
            if (out_valid && out_ready) begin
                got++;
                check("t4_order", out_data, beat_out(got));
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            if (acc) next++;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("t4_received", got, 20);
        check("t4_accepted", next, 21);
        check("t4_latency", first_val - first_acc, 2);
        tick();
        tick();
        check("t4_no_dup", out_valid, 0);

        // Overflow counter
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("t5_clear_idle", ovf_count, 0);
        check("t5_clear_idle_c4", c_count, 0);
        in_valid = 1'b1;
        in_data  = sat_beat;
        rnd_mode = 2'd0;
        repeat (10) tick();
        in_valid = 1'b0;
        check("t5_sat_data", out_data, {6'h1f, 6'h20, 6'h00, 6'h00});
        check("t5_sat_ovf", out_ovf, 4'b1100);
        check("t5_sat_ovf_c4", c_out_ovf, 4'b1100);
        tick();
        tick();
        check("t5_drained", out_valid, 0);
        check("t5_count", ovf_count, 20);
        check("t5_count_c4_sat", c_count, 4'hf);
        send(sat_beat, 2'd0);
        tick();
        check("t5_pre_clear_valid", out_valid, 1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("t5_clear_xfer", ovf_count, 0);
        check("t5_clear_xfer_c4", c_count, 0);
        check("t5_clear_consumed", out_valid, 0);

        // Reset with both stages full
        send(sat_beat, 2'd0);
        tick();
        tick();
        check("t6_count", ovf_count, 2);
        out_ready = 1'b0;
        send(beat_in(5), 2'd0);
        send(beat_in(6), 2'd0);
        check("t6_full_valid", out_valid, 1);
        check("t6_full_ready", in_ready, 0);
        check("t6_full_data", out_data, beat_out(5));
        reset = 1'b1;
        tick();
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_count", ovf_count, 0);
        check("t6_rst_ready", in_ready, 0);
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t6_ready_after", in_ready, 1);
        check("t6_quiet1", out_valid, 0);
        tick();
        check("t6_quiet2", out_valid, 0);
        send(beat_in(7), 2'd0);
        check("t6_new_early", out_valid, 0);
        tick();
        check("t6_new_valid", out_valid, 1);
        check("t6_new_data", out_data, beat_out(7));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fx_requant_pipe.md
Name: fx_requant_pipe

Overview:
Multi-lane, pipelined fixed-point format converter for the DNN datapath. Each lane takes a signed word in format (from_width, from_sign_bits, from_int_bits) and produces it in format (width, sign_bits, int_bits).
- Rounding mode is selectable at runtime; saturation is always applied.
- Sits between accumulator/activation stages and the next layer's operand buffers.
- Adds a valid/ready pipeline, per-beat overflow flags and a saturating overflow counter for profiling.

Parameters:
lanes, 4, number of parallel conversion lanes sharing one handshake
from_width, 12, input word width per lane
from_sign_bits, 1, input sign bits (1 sign + redundant copies)
from_int_bits, 3, input integer bits excluding sign; frac = from_width - from_sign_bits - from_int_bits
width, 6, output word width per lane
sign_bits, 1, output sign bits
int_bits, 2, output integer bits; frac = width - sign_bits - int_bits
cnt_width, 16, overflow counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_data  in  lanes*from_width  lane i at [i*from_width +: from_width]
rnd_mode  in  2  0 = truncate (floor), 1 = round half up, 2 = round half even, 3 = reserved (behaves as 1); sampled with the beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  lanes*width  converted lanes, same packing
out_ovf  out  lanes  per-lane saturation occurred on this beat
ovf_count  out  cnt_width  total saturated lanes since reset/clear, sticks at all-ones
ovf_clear  in  1  synchronous clear of ovf_count

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Value semantics: word value = signed integer × 2^-frac. Legal output range is [-2^int_bits, 2^int_bits - 2^-frac_out]. All sign_bits output bits equal the sign.
- Input redundant sign bits are ignored; only the low (from_int_bits + 1 + frac_in) bits are interpreted.
- Frac change:
  - If frac_out >= frac_in: left shift, exact, no rounding.
  - Else: right shift by d = frac_in - frac_out.
  - Truncate: arithmetic floor.
  - Half up: add 2^(d-1), then floor.
  - Half even: add 2^(d-1) unless the discarded bits equal exactly 2^(d-1) and the kept LSB is 0; then floor.
  - Rounding is done at full precision (one guard bit above the input MSB) so it cannot wrap.
- Saturation after rounding:
  - Value > max → max pattern (sign bits 0, rest 1), out_ovf[i] = 1.
  - Value < min → min pattern (sign bits 1, rest 0), out_ovf[i] = 1.
  - Otherwise exact, out_ovf[i] = 0.
- Pipeline: 2 stages.
  - S1 registers the sign-extended, rounded intermediate and the mode.
  - S2 registers saturated output and flags.
  - Latency is 2 cycles from an in_valid&&in_ready edge to out_valid with no stall.
  - Full throughput is 1 beat/cycle.
- Handshake:
  - A stage advances when it is empty or the stage after it advances. in_ready = S1 empty || S1 advances.
  - While out_valid && !out_ready, out_data, out_ovf and out_valid hold stable.
  - in_valid is not allowed to depend on in_ready.
  - No beat is dropped or duplicated under any out_ready pattern.
- ovf_count:
  - Adds popcount(out_ovf) on each cycle with out_valid && out_ready, saturating at 2^cnt_width - 1.
  - ovf_clear has priority: if clear coincides with a transfer, count = 0 (the transferring beat is not counted).
- Reset values: in_ready = 0 during reset, 1 the cycle after; out_valid = 0; out_data = 0; out_ovf = 0; ovf_count = 0. Both stage valid bits are cleared.
- Reset mid-operation: in-flight beats are discarded; nothing emerges afterward.
- Elaboration checks: each format must have frac >= 0 and sign bits >= 1; violations are a $fatal.

Decomposition:
- Package fx_pkg:
  - rnd_mode_e enum (RND_TRUNC, RND_HALF_UP, RND_HALF_EVEN).
  - Functions computing frac, max and min patterns from (width, sign_bits, int_bits).
- Sub-module fx_lane_conv: combinational per-lane round + saturate, split at the S1/S2 boundary by a stage-select parameter. It is instantiated lanes times via generate.
- fx_requant_pipe owns only handshake, registers and the counter.

Test Plan:
1. Defaults, lane0 = 12'h2ff (3 - 2^-8), rnd_mode = 1 → out lane0 = 6'h18, ovf = 0. Same input with rnd_mode = 0 → 6'h17.
2. rnd_mode = 2, lanes = {12'h010, 12'h030, 12'hff0, 12'h7ff} → {6'h00, 6'h02, 6'h00, 6'h1f}. Lane 3 saturates, ovf = 4'b1000. rnd_mode = 1 on the same inputs → {6'h01, 6'h02, 6'h00, 6'h1f}.
3. Instance from (26,2,24) to (12,1,3), input 26'h3fffff2 (-14) → 12'h800, ovf = 1. Instance (12,1,3) to (24,2,6), input 12'h7ff → 24'h07ff00, ovf = 0.
4. Back-to-back beats 1..20 with out_ready toggling pseudo-randomly → outputs in order, none lost or duplicated, output stable while stalled, first out_valid 2 cycles after first accept.
5. Stream 10 beats each with 2 saturating lanes → ovf_count = 20. Assert ovf_clear on a transfer cycle → count 0 next cycle. cnt_width = 4 instance saturates at 4'hf.
6. Reset asserted with both stages full and out_ready = 0 → next cycle out_valid = 0, ovf_count = 0. Following beat emerges after 2 cycles with correct value.
